zoom_sequencer: RTL and testbench

Sequences the pixel-scaling datapath for one complete zoom operation. It latches the selected algorithm on START and walks the source or destination raster. It issues reads to the source frame memory (1-cycle read latency) and writes to the destination frame memory. It runs nearest-neighbour 2x, pixel-replication 2x, decimation 1/2 and block-average 1/2, sits between the algorithm-select/zoom-state logic and the two frame RAMs, and reports BUSY/DONE.

---
 rtl/zoom_sequencer_pkg.sv | 28 ++
 rtl/zoom_sequencer_addr_gen.sv | 56 +++++
 rtl/zoom_sequencer.sv | 165 ++++++++++++++++
 tb/tb_zoom_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zoom_sequencer_pkg.sv
// Shared codes for the zoom datapath: algorithm select values, sequencer
// state encodings and the address-width helper.
package zoom_sequencer_pkg;

   typedef enum logic [1:0] {
      ALG_NN = 2'd0,
      ALG_PR = 2'd1,
      ALG_DC = 2'd2,
      ALG_BA = 2'd3
   } alg_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_EMIT  = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

   // Ceiling log2, never less than 1 so every address bus has at least one bit.
   function automatic int addr_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/zoom_sequencer_addr_gen.sv
// Combinational mapping from loop position (alg, x, y, k) to source read
// and destination write addresses for each zoom algorithm.
module zoom_addr_gen
   import zoom_sequencer_pkg::*;
#(
   parameter int SRC_W  = 160,
   parameter int XW     = 9,
   parameter int YW     = 8,
   parameter int SRC_AW = 15,
   parameter int DST_AW = 17
) (
   input  alg_t              alg,
   input  logic [XW-1:0]     x,
   input  logic [YW-1:0]     y,
   input  logic [1:0]        k,
   output logic [SRC_AW-1:0] rd_addr,
   output logic [DST_AW-1:0] wr_addr
);

   localparam logic [DST_AW-1:0] W_C  = DST_AW'(SRC_W);
   localparam logic [DST_AW-1:0] W2_C = DST_AW'(2 * SRC_W);
   localparam logic [DST_AW-1:0] WH_C = DST_AW'(SRC_W / 2);

   logic [DST_AW-1:0] xw, yw, k0, k1, rd_w, wr_w;

   always_comb begin
      xw   = DST_AW'(x);
      yw   = DST_AW'(y);
      k0   = DST_AW'(k[0]);
      k1   = DST_AW'(k[1]);
      rd_w = '0;
      wr_w = '0;
      case (alg)
         ALG_NN: begin
            rd_w = (yw >> 1) * W_C + (xw >> 1);
            wr_w = yw * W2_C + xw;
         end
         ALG_PR: begin
            rd_w = yw * W_C + xw;
            wr_w = ((yw << 1) + k1) * W2_C + (xw << 1) + k0;
         end
         ALG_DC: begin
            rd_w = (yw << 1) * W_C + (xw << 1);
            wr_w = yw * WH_C + xw;
         end
         default: begin
            // Block average: k walks the 2x2 source quad in raster order.
            rd_w = ((yw << 1) + k1) * W_C + (xw << 1) + k0;
            wr_w = yw * WH_C + xw;
         end
      endcase
      rd_addr = SRC_AW'(rd_w);
      wr_addr = wr_w;
   end

endmodule

// File: rtl/zoom_sequencer.sv
// Sequencer for one zoom operation: walks the raster for the latched
// algorithm, reads the source frame RAM and writes the destination frame RAM.
module zoom_sequencer
   import zoom_sequencer_pkg::*;
#(
   parameter  int SRC_W  = 160,
   parameter  int SRC_H  = 120,
   parameter  int DATA_W = 8,
   localparam int SRC_AW = addr_clog2(SRC_W * SRC_H),
   localparam int DST_AW = addr_clog2(4 * SRC_W * SRC_H)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              START,
   input  logic              ABORT,
   input  logic [1:0]        ALGORITHM,
   output logic              RD_EN,
   output logic [SRC_AW-1:0] RD_ADDR,
   input  logic [DATA_W-1:0] RD_DATA,
   output logic              WR_EN,
   output logic [DST_AW-1:0] WR_ADDR,
   output logic [DATA_W-1:0] WR_DATA,
   output logic              BUSY,
   output logic              DONE,
   output logic [1:0]        ALG_ACTIVE,
   output logic [2:0]        DBG_STATE
);

   localparam int XW    = addr_clog2(2 * SRC_W);
   localparam int YW    = addr_clog2(2 * SRC_H);
   localparam int ACC_W = DATA_W + 2;

   state_t             state, state_n;
   alg_t               alg, alg_n;
   logic [XW-1:0]      x, x_n, x_max;
   logic [YW-1:0]      y, y_n, y_max;
   logic [1:0]         k, k_n;
   logic [ACC_W-1:0]   acc, acc_n;
   logic [DATA_W-1:0]  pix, pix_n;
   logic [SRC_AW-1:0]  rd_addr;
   logic [DST_AW-1:0]  wr_addr;
   logic               last;

   zoom_addr_gen #(
      .SRC_W (SRC_W),
      .XW    (XW),
      .YW    (YW),
      .SRC_AW(SRC_AW),
      .DST_AW(DST_AW)
   ) u_addr_gen (
      .alg    (alg),
      .x      (x),
      .y      (y),
      .k      (k),
      .rd_addr(rd_addr),
      .wr_addr(wr_addr)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= ST_IDLE;
         alg   <= ALG_NN;
         x     <= '0;
         y     <= '0;
         k     <= '0;
         acc   <= '0;
         pix   <= '0;
      end else begin
         state <= state_n;
         alg   <= alg_n;
         x     <= x_n;
         y     <= y_n;
         k     <= k_n;
         acc   <= acc_n;
         pix   <= pix_n;
      end
   end

   // Enlarging modes loop over the output raster except PR, which loops over source.
   always_comb begin
      case (alg)
         ALG_NN: begin
            x_max = XW'(2 * SRC_W - 1);
            y_max = YW'(2 * SRC_H - 1);
         end
         ALG_PR: begin
            x_max = XW'(SRC_W - 1);
            y_max = YW'(SRC_H - 1);
         end
         default: begin
            x_max = XW'(SRC_W / 2 - 1);
            y_max = YW'(SRC_H / 2 - 1);
         end
      endcase
      last = (x == x_max) && (y == y_max);
   end

   always_comb begin
      state_n = state;
      alg_n   = alg;
      x_n     = x;
      y_n     = y;
      k_n     = k;
      acc_n   = acc;
      pix_n   = pix;
      case (state)
         ST_IDLE: begin
            if (START) begin
               alg_n   = alg_t'(ALGORITHM);
               x_n     = '0;
               y_n     = '0;
               k_n     = '0;
               acc_n   = '0;
               state_n = ST_FETCH;
            end
         end
         ST_FETCH: state_n = ST_WAIT;
         ST_WAIT: begin
            pix_n   = RD_DATA;
            state_n = ST_EMIT;
            if (alg == ALG_BA) begin
               acc_n = acc + ACC_W'(RD_DATA);
               if (k != 2'd3) begin
                  k_n     = k + 2'd1;
                  state_n = ST_FETCH;
               end
            end
         end
         ST_EMIT: begin
            if (alg == ALG_PR && k != 2'd3) begin
               k_n = k + 2'd1;
            end else begin
               k_n   = '0;
               acc_n = '0;
               if (last) begin
                  state_n = ST_FIN;
               end else begin
                  state_n = ST_FETCH;
                  if (x == x_max) begin
                     x_n = '0;
                     y_n = y + YW'(1);
                  end else begin
                     x_n = x + XW'(1);
                  end
               end
            end
         end
         ST_FIN:  state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
      // Abort overrides everything except an idle START, which has priority.
      if (ABORT && state != ST_IDLE) state_n = ST_IDLE;
   end

   assign RD_EN      = (state == ST_FETCH);
   assign WR_EN      = (state == ST_EMIT);
   assign BUSY       = (state == ST_FETCH) || (state == ST_WAIT) || (state == ST_EMIT);
   assign DONE       = (state == ST_FIN);
   assign ALG_ACTIVE = alg;
   assign DBG_STATE  = state;
   assign RD_ADDR    = RD_EN ? rd_addr : '0;
   assign WR_ADDR    = WR_EN ? wr_addr : '0;
   assign WR_DATA    = !WR_EN ? '0 : (alg == ALG_BA) ? acc[ACC_W-1:2] : pix;

endmodule

// File: tb/tb_zoom_sequencer.sv
// Directed bench for zoom_sequencer on a 4x4 source frame where src[i] = i,
// with behavioural source/destination frame memories.
module tb_zoom_sequencer;

   localparam int SRC_W  = 4;
   localparam int SRC_H  = 4;
   localparam int DATA_W = 8;
   localparam int SRC_AW = 4;
   localparam int DST_AW = 6;

   logic              CLK = 1'b0;
   logic              RESET_N = 1'b0;
   logic              START = 1'b0;
   logic              ABORT = 1'b0;
   logic [1:0]        ALGORITHM = 2'd0;
   logic              RD_EN;
   logic [SRC_AW-1:0] RD_ADDR;
   logic [DATA_W-1:0] RD_DATA = '0;
   logic              WR_EN;
   logic [DST_AW-1:0] WR_ADDR;
   logic [DATA_W-1:0] WR_DATA;
   logic              BUSY;
   logic              DONE;
   logic [1:0]        ALG_ACTIVE;
   logic [2:0]        DBG_STATE;

   logic [DATA_W-1:0] dst [64];
   logic              clr = 1'b0;
   int                rd_cnt = 0;
   int                wr_cnt = 0;
   int                errors = 0;
   int                checks = 0;

   zoom_sequencer #(.SRC_W(SRC_W), .SRC_H(SRC_H), .DATA_W(DATA_W)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
      .ALGORITHM(ALGORITHM), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
      .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY),
      .DONE(DONE), .ALG_ACTIVE(ALG_ACTIVE), .DBG_STATE(DBG_STATE)
   );

   // clock / memory models
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (RD_EN) begin
         RD_DATA <= DATA_W'(RD_ADDR);
         rd_cnt  <= rd_cnt + 1;
      end
      if (WR_EN) wr_cnt <= wr_cnt + 1;
      if (clr) begin
         for (int i = 0; i < 64; i++) dst[i] <= 8'hEE;
      end else if (WR_EN) begin
         dst[WR_ADDR] <= WR_DATA;
      end
   end

   function automatic logic [7:0] up2_expect(input int idx);
      return 8'(((idx / 8) >> 1) * 4 + ((idx % 8) >> 1));
   endfunction

   // driver tasks
   task automatic clear_dst();
      @(negedge CLK) clr = 1'b1;
      @(negedge CLK) clr = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] a, output int cyc);
      @(negedge CLK);
      START = 1'b1;
      ALGORITHM = a;
      @(negedge CLK);
      START = 1'b0;
      cyc = 1;
      while (!DONE && cyc < 2000) begin
         @(negedge CLK);
         cyc++;
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({RD_EN, WR_EN, BUSY, DONE, ALG_ACTIVE} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=000000", {RD_EN, WR_EN, BUSY, DONE, ALG_ACTIVE});
      end
      checks++;
      if ({RD_ADDR, WR_ADDR, WR_DATA} !== '0) begin
         errors++;
         $display("FAIL reset_bus got rd=%0d wr=%0d data=%0d exp=0", RD_ADDR, WR_ADDR, WR_DATA);
      end
      @(negedge CLK) RESET_N = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || rd_cnt != 0) begin
         errors++;
         $display("FAIL reset_idle got busy=%b reads=%0d exp busy=0 reads=0", BUSY, rd_cnt);
      end
   endtask

   task automatic test_dc();
      int cyc, w0;
      clear_dst();
      w0 = wr_cnt;
      run_op(2'd2, cyc);
      checks++;
      if (cyc != 13) begin errors++; $display("FAIL dc_done_cycle got=%0d exp=13", cyc); end
      checks++;
      if (wr_cnt - w0 != 4) begin errors++; $display("FAIL dc_writes got=%0d exp=4", wr_cnt - w0); end
      checks++;
      if ({dst[0], dst[1], dst[2], dst[3]} !== {8'd0, 8'd2, 8'd8, 8'd10}) begin
         errors++;
         $display("FAIL dc_pixels got=%0d,%0d,%0d,%0d exp=0,2,8,10", dst[0], dst[1], dst[2], dst[3]);
      end
      checks++;
      if (ALG_ACTIVE !== 2'd2) begin errors++; $display("FAIL dc_alg got=%0d exp=2", ALG_ACTIVE); end
   endtask

   task automatic test_ba();
      int cyc, w0, r0;
      clear_dst();
      w0 = wr_cnt;
      r0 = rd_cnt;
      run_op(2'd3, cyc);
      checks++;
      if (cyc != 37) begin errors++; $display("FAIL ba_done_cycle got=%0d exp=37", cyc); end
      checks++;
      if (rd_cnt - r0 != 16 || wr_cnt - w0 != 4) begin
         errors++;
         $display("FAIL ba_counts got rd=%0d wr=%0d exp rd=16 wr=4", rd_cnt - r0, wr_cnt - w0);
      end
      checks++;
      if ({dst[0], dst[1], dst[2], dst[3]} !== {8'd2, 8'd4, 8'd10, 8'd12}) begin
         errors++;
         $display("FAIL ba_pixels got=%0d,%0d,%0d,%0d exp=2,4,10,12", dst[0], dst[1], dst[2], dst[3]);
      end
   endtask

   task automatic test_pr();
      int cyc, w0, r0, bad;
      clear_dst();
      w0 = wr_cnt;
      r0 = rd_cnt;
      run_op(2'd1, cyc);
      checks++;
      if (cyc != 97) begin errors++; $display("FAIL pr_done_cycle got=%0d exp=97", cyc); end
      checks++;
      if (rd_cnt - r0 != 16 || wr_cnt - w0 != 64) begin
         errors++;
         $display("FAIL pr_counts got rd=%0d wr=%0d exp rd=16 wr=64", rd_cnt - r0, wr_cnt - w0);
      end
      checks++;
      if ({dst[34], dst[35], dst[42], dst[43]} !== {4{8'd9}}) begin
         errors++;
         $display("FAIL pr_block got=%0d,%0d,%0d,%0d exp=9,9,9,9", dst[34], dst[35], dst[42], dst[43]);
      end
      bad = 0;
      for (int i = 0; i < 64; i++) if (dst[i] !== up2_expect(i)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL pr_image got=%0d bad pixels exp=0", bad); end
      checks++;
      if (ALG_ACTIVE !== 2'd1) begin errors++; $display("FAIL pr_alg got=%0d exp=1", ALG_ACTIVE); end
   endtask

   task automatic test_nn();
      int cyc, w0, r0, bad;
      clear_dst();
      w0 = wr_cnt;
      r0 = rd_cnt;
      run_op(2'd0, cyc);
      checks++;
      if (cyc != 193) begin errors++; $display("FAIL nn_done_cycle got=%0d exp=193", cyc); end
      checks++;
      if (rd_cnt - r0 != 64 || wr_cnt - w0 != 64) begin
         errors++;
         $display("FAIL nn_counts got rd=%0d wr=%0d exp rd=64 wr=64", rd_cnt - r0, wr_cnt - w0);
      end
      checks++;
      if (dst[43] !== 8'd9) begin errors++; $display("FAIL nn_pixel43 got=%0d exp=9", dst[43]); end
      bad = 0;
      for (int i = 0; i < 64; i++) if (dst[i] !== up2_expect(i)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL nn_image got=%0d bad pixels exp=0", bad); end
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || ALG_ACTIVE !== 2'd0) begin
         errors++;
         $display("FAIL nn_after got busy=%b done=%b alg=%0d exp 0,0,0", BUSY, DONE, ALG_ACTIVE);
      end
   endtask

   task automatic test_ignore_start();
      int cyc, w0, bad;
      clear_dst();
      w0 = wr_cnt;
      @(negedge CLK);
      START = 1'b1;
      ALGORITHM = 2'd0;
      @(negedge CLK);
      START = 1'b0;
      cyc = 1;
      while (!DONE && cyc < 2000) begin
         @(negedge CLK);
         cyc++;
         START = (cyc == 10);
         ALGORITHM = (cyc >= 10 && cyc < 30) ? 2'd3 : 2'd0;
      end
      START = 1'b0;
      ALGORITHM = 2'd0;
      checks++;
      if (cyc != 193) begin errors++; $display("FAIL ign_done_cycle got=%0d exp=193", cyc); end
      bad = 0;
      for (int i = 0; i < 64; i++) if (dst[i] !== up2_expect(i)) bad++;
      checks++;
      if (bad != 0 || wr_cnt - w0 != 64 || ALG_ACTIVE !== 2'd0) begin
         errors++;
         $display("FAIL ign_result got bad=%0d wr=%0d alg=%0d exp 0,64,0", bad, wr_cnt - w0, ALG_ACTIVE);
      end
   endtask

   task automatic test_abort();
      int cyc, w0, w_ab, stray;
      w0 = wr_cnt;
      @(negedge CLK);
      START = 1'b1;
      ALGORITHM = 2'd0;
      @(negedge CLK);
      START = 1'b0;
      repeat (19) @(negedge CLK);
      ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
      checks++;
      if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", BUSY); end
      w_ab = wr_cnt;
      stray = 0;
      repeat (20) begin
         if (DONE || WR_EN || RD_EN) stray++;
         @(negedge CLK);
      end
      checks++;
      if (stray != 0 || wr_cnt != w_ab) begin
         errors++;
         $display("FAIL abort_quiet got stray=%0d extra_wr=%0d exp=0,0", stray, wr_cnt - w_ab);
      end
      checks++;
      if (w_ab - w0 != 6) begin errors++; $display("FAIL abort_writes got=%0d exp=6", w_ab - w0); end
      clear_dst();
      run_op(2'd2, cyc);
      checks++;
      if (cyc != 13 || {dst[0], dst[1], dst[2], dst[3]} !== {8'd0, 8'd2, 8'd8, 8'd10}) begin
         errors++;
         $display("FAIL abort_restart got cyc=%0d pix=%0d,%0d,%0d,%0d exp 13,0,2,8,10",
                  cyc, dst[0], dst[1], dst[2], dst[3]);
      end
   endtask

   task automatic test_abort_with_start();
      int cyc;
      @(negedge CLK);
      START = 1'b1;
      ABORT = 1'b1;
      ALGORITHM = 2'd2;
      @(negedge CLK);
      START = 1'b0;
      ABORT = 1'b0;
      checks++;
      if (BUSY !== 1'b1 || ALG_ACTIVE !== 2'd2) begin
         errors++;
         $display("FAIL start_wins got busy=%b alg=%0d exp 1,2", BUSY, ALG_ACTIVE);
      end
      cyc = 1;
      while (!DONE && cyc < 200) begin
         @(negedge CLK);
         cyc++;
      end
      checks++;
      if (cyc != 13) begin errors++; $display("FAIL start_wins_done got=%0d exp=13", cyc); end
   endtask

   task automatic test_reset_mid();
      int cyc, r0;
      @(negedge CLK);
      START = 1'b1;
      ALGORITHM = 2'd3;
      @(negedge CLK);
      START = 1'b0;
      repeat (14) @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      checks++;
      if ({RD_EN, WR_EN, BUSY, DONE, ALG_ACTIVE} !== 6'b0) begin
         errors++;
         $display("FAIL midreset_out got=%b exp=000000", {RD_EN, WR_EN, BUSY, DONE, ALG_ACTIVE});
      end
      @(negedge CLK) RESET_N = 1'b1;
      r0 = rd_cnt;
      repeat (10) @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || rd_cnt != r0) begin
         errors++;
         $display("FAIL midreset_idle got busy=%b reads=%0d exp 0,0", BUSY, rd_cnt - r0);
      end
      clear_dst();
      run_op(2'd3, cyc);
      checks++;
      if (cyc != 37 || dst[0] !== 8'd2 || dst[3] !== 8'd12) begin
         errors++;
         $display("FAIL midreset_rerun got cyc=%0d d0=%0d d3=%0d exp 37,2,12", cyc, dst[0], dst[3]);
      end
   endtask

   initial begin
      test_reset();
      test_dc();
      test_ba();
      test_pr();
      test_nn();
      test_ignore_start();
      test_abort();
      test_abort_with_start();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
